// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts one ALU command at a time, drives it onto an external ALU for
// ALU_LATENCY+1 cycles, captures the result and flags, and holds them as a response until
// the consumer takes it.
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_opcode, cmd_a, cmd_b command payload
//   en, oe, opcode, a, b        ALU enable/output enable and latched operation to the ALU
//   alu_out, cf, of, sf, zf     ALU result and flags
//   rsp_valid/rsp_ready         response handshake; rsp_data, rsp_flags {cf,of,sf,zf}, rsp_err
//   op_count                    number of completed legal operations (wraps)
module alu_cmd_issuer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ALU_LATENCY = 1  // legal 1..4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             en,
  output logic             oe,
  output logic [3:0]       opcode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             cf,
  input  logic             of,
  input  logic             sf,
  input  logic             zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  localparam logic [2:0] WaitLast = 3'(ALU_LATENCY - 1);

  state_e           state_q, state_d;
  logic [2:0]       wait_cnt_q, wait_cnt_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             cmd_legal;

  assign cmd_legal = (cmd_opcode >= 4'd2) && (cmd_opcode <= 4'd7);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          opcode_d = cmd_opcode;
          a_d      = cmd_a;
          b_d      = cmd_b;
          if (cmd_legal) begin
            state_d = StIssue;
          end else begin
            // Illegal opcodes never reach the ALU: answer with an error right away.
            state_d     = StRespond;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_flags_d = '0;
          end
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          state_d     = StRespond;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = alu_out;
          rsp_flags_d = {cf, of, sf, zf};
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StRespond: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          if (!rsp_err_q) begin
            op_count_d = op_count_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  // Gated by rst_n so the command port reads not-ready for the whole reset window.
  assign cmd_ready = (state_q == StIdle) && rst_n;
  assign en        = (state_q == StIssue) || (state_q == StWait);
  assign oe        = en;
  assign opcode    = opcode_q;
  assign a         = a_q;
  assign b         = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width.
REQ-002 SHALL have parameter ALU_LATENCY, default 1, legal range 1..4: rising edges from ALU sample to ALU_OUT valid.
REQ-003 SHALL have port CLK  input  1  single clock, rising-edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port CMD_VALID  input  1  command offered.
REQ-006 SHALL have port CMD_READY  output  1  command accepted this edge if CMD_VALID.
REQ-007 SHALL have port CMD_OPCODE  input  4  requested ALU opcode.
REQ-008 SHALL have ports CMD_A, CMD_B  input  WIDTH  requested operands.
REQ-009 SHALL have ports EN, OE  output  1  ALU enable / output enable.
REQ-010 SHALL have port OPCODE  output  4  opcode to ALU.
REQ-011 SHALL have ports A, B  output  WIDTH  operands to ALU.
REQ-012 SHALL have port ALU_OUT  input  WIDTH  ALU result.
REQ-013 SHALL have ports CF, OF, SF, ZF  input  1  ALU flags.
REQ-014 SHALL have port RSP_VALID  output  1  response available.
REQ-015 SHALL have port RSP_READY  input  1  response consumed this edge if RSP_VALID.
REQ-016 SHALL have port RSP_DATA  output  WIDTH  captured result.
REQ-017 SHALL have port RSP_FLAGS  output  4  captured {CF,OF,SF,ZF}.
REQ-018 SHALL have port RSP_ERR  output  1  illegal-opcode response.
REQ-019 SHALL have port OP_COUNT  output  16  completed legal operations.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND.
REQ-021 SHALL drive CMD_READY=1 only in IDLE; command accepted on rising edge with CMD_VALID&&CMD_READY; CMD_VALID otherwise ignored.
REQ-022 SHALL latch CMD_OPCODE/CMD_A/CMD_B on accept; legal opcodes 2..7 -> ISSUE.
REQ-023 SHALL treat opcodes 0,1,8..15 as illegal: IDLE -> RESPOND on accept edge, RSP_ERR=1, RSP_DATA=0, RSP_FLAGS=0, EN/OE never asserted.
REQ-024 SHALL assert EN=1, OE=1 with latched OPCODE/A/B in ISSUE (one cycle) and in WAIT; operands held stable throughout.
REQ-025 SHALL remain in WAIT exactly ALU_LATENCY cycles, then capture ALU_OUT and flags on the edge leaving WAIT and enter RESPOND.
REQ-026 SHALL assert RSP_VALID ALU_LATENCY+2 rising edges after the legal accept edge, 1 edge after an illegal accept edge.
REQ-027 SHALL drive EN=0, OE=0 in IDLE and RESPOND; OPCODE/A/B retain last values.
REQ-028 SHALL hold RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR stable in RESPOND until RSP_VALID&&RSP_READY edge, then go IDLE and clear RSP_VALID/RSP_ERR.
REQ-029 SHALL ignore RSP_READY outside RESPOND; one command in flight maximum.
REQ-030 SHALL increment OP_COUNT by 1 on each non-error response handshake, wrapping 0xFFFF -> 0x0000; error responses do not count.

Reset
REQ-031 SHALL on RST_N low, asynchronously: state IDLE; EN, OE, OPCODE, A, B, RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR, OP_COUNT = 0; CMD_READY=0 while RST_N low.
REQ-032 SHALL abort any in-flight command on reset mid-operation, discarding it with no response.
REQ-033 SHALL assert CMD_READY=1 in the first cycle after RST_N rises.

Verification (WIDTH=8, ALU_LATENCY=1 unless stated)
REQ-034 SHALL check: opcode 2, A=3, B=1 -> EN/OE/OPCODE=2/A=3/B=1 for 2 cycles, RSP_VALID 3 edges after accept, RSP_DATA=4, OP_COUNT=1 after handshake.
REQ-035 SHALL check: opcode 3, A=15, B=15 -> RSP_DATA=0, RSP_FLAGS[0] (ZF)=1, RSP_ERR=0.
REQ-036 SHALL check: opcode 15 -> RSP_VALID next cycle, RSP_ERR=1, RSP_DATA=0, EN never high, OP_COUNT unchanged.
REQ-037 SHALL check: opcode 4, A=0xAA, B=0x55, RSP_READY low 5 cycles -> RSP_DATA=0x00 stable, CMD_READY=0 despite CMD_VALID=1; release -> IDLE next cycle.
REQ-038 SHALL check: RST_N low during WAIT -> EN/OE/RSP_VALID/OP_COUNT=0 immediately, no response; next command after release completes normally.
REQ-039 SHALL check: ALU_LATENCY=3, opcode 6, A=0x0F, B=0xFF -> 4 cycles EN high, RSP_VALID 5 edges after accept, RSP_DATA=0xF0.
